// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared constants and helpers for the Johnson counter
// Purpose: direction encoding and the phase-index width function used by
//          johnson_counter_param and johnson_phase_decode.
// Ports:   none (package)
package johnson_pkg;

  localparam logic DIR_UP   = 1'b0;  // shift left, phase increments
  localparam logic DIR_DOWN = 1'b1;  // shift right, phase decrements

  // Width of a binary index covering all 2*width Johnson states.
  function automatic int ph_width(input int width);
    return $clog2(2 * width);
  endfunction

endpackage

// File: rtl/johnson_phase_decode.sv
// rtl/johnson_phase_decode.sv - legality check and phase index of a Johnson code
// Purpose: combinational decode of a WIDTH-bit twisted-ring code.
// Ports:
//   code   in  WIDTH  candidate Johnson code
//   legal  out 1      code is one of the 2*WIDTH thermometer patterns
//   phase  out PH_W   binary index 0..2*WIDTH-1 (meaningless when legal=0)
module johnson_phase_decode
  import johnson_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int PH_W  = ph_width(WIDTH)
) (
  input  logic [WIDTH-1:0] code,
  output logic             legal,
  output logic [PH_W-1:0]  phase
);

  logic [WIDTH-1:0] w_inv;
  logic [WIDTH-1:0] w_code_inc;
  logic [WIDTH-1:0] w_inv_inc;
  logic [PH_W-1:0]  w_ones;

  // x & (x+1) == 0 exactly when x is 0..01..1; the inverted code covers 1..10..0.
  assign w_inv      = ~code;
  assign w_code_inc = code + WIDTH'(1);
  assign w_inv_inc  = w_inv + WIDTH'(1);
  assign legal      = ((code & w_code_inc) == '0) || ((w_inv & w_inv_inc) == '0);

  always_comb begin
    w_ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_ones = w_ones + PH_W'(code[i]);
    end
  end

  // Second half of the sequence (ones packed at the MSB end) counts down from
  // 2*WIDTH. The subtraction wraps modulo 2^PH_W, which is harmless because the
  // true result is always below 2*WIDTH and so fits in PH_W bits.
  always_comb begin
    phase = w_ones;
    if ((code != '0) && !code[0]) begin
      phase = PH_W'(2 * WIDTH) - w_ones;
    end
  end

endmodule

// File: rtl/johnson_counter_param.sv
// rtl/johnson_counter_param.sv - parametrised Johnson counter with load, direction and self-correction
// Purpose: 2*WIDTH-phase twisted-ring sequencer with enable, up/down, synchronous
//          load, illegal-state recovery, binary phase output and wrap pulse.
// Ports:
//   clk       in  1      rising-edge clock
//   reset_n   in  1      asynchronous active-low reset
//   en        in  1      count enable, one step per clk
//   dir       in  1      0 = up (shift left), 1 = down (shift right)
//   load      in  1      synchronous load strobe (highest priority)
//   load_val  in  WIDTH  value loaded when load=1; illegal codes are rejected
//   q_out     out WIDTH  registered counter state
//   phase     out PH_W   combinational phase index of q_out
//   wrap      out 1      registered pulse after an en step crosses the 2*WIDTH-1/0 boundary
//   err       out 1      registered pulse after an illegal state or illegal load was replaced by 0
module johnson_counter_param
  import johnson_pkg::*;
#(
  parameter  int               WIDTH     = 4,
  parameter  logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int               PH_W      = ph_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q_out,
  output logic [PH_W-1:0]  phase,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] RV_INC     = RESET_VAL + WIDTH'(1);
  localparam logic [WIDTH-1:0] RV_INV     = ~RESET_VAL;
  localparam logic [WIDTH-1:0] RV_INV_INC = RV_INV + WIDTH'(1);
  localparam bit RV_LEGAL = ((RESET_VAL & RV_INC) == '0) || ((RV_INV & RV_INV_INC) == '0);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * WIDTH - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("johnson_counter_param: WIDTH must be >= 2");
  end
  if (!RV_LEGAL) begin : g_bad_reset_val
    $error("johnson_counter_param: RESET_VAL is not a legal Johnson code");
  end

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_err;

  logic             w_q_legal;
  logic [PH_W-1:0]  w_q_phase;
  logic             w_ld_legal;
  logic [PH_W-1:0]  w_ld_phase_unused;

  logic [WIDTH-1:0] w_q_next;
  logic             w_wrap_next;
  logic             w_err_next;

  johnson_phase_decode #(.WIDTH(WIDTH)) u_q_decode (
    .code  (r_q),
    .legal (w_q_legal),
    .phase (w_q_phase)
  );

  johnson_phase_decode #(.WIDTH(WIDTH)) u_ld_decode (
    .code  (load_val),
    .legal (w_ld_legal),
    .phase (w_ld_phase_unused)
  );

  // Priority: load > illegal-state correction > enabled step > hold.
  always_comb begin
    w_q_next    = r_q;
    w_wrap_next = 1'b0;
    w_err_next  = 1'b0;
    if (load) begin
      if (w_ld_legal) begin
        w_q_next = load_val;
      end else begin
        w_q_next   = '0;
        w_err_next = 1'b1;
      end
    end else if (!w_q_legal) begin
      w_q_next   = '0;
      w_err_next = 1'b1;
    end else if (en) begin
      if (dir == DIR_UP) begin
        w_q_next    = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
        w_wrap_next = (w_q_phase == PH_LAST);
      end else begin
        w_q_next    = {~r_q[0], r_q[WIDTH-1:1]};
        w_wrap_next = (w_q_phase == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q    <= RESET_VAL;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_wrap <= w_wrap_next;
      r_err  <= w_err_next;
    end
  end

  assign q_out = r_q;
  assign phase = w_q_phase;
  assign wrap  = r_wrap;
  assign err   = r_err;

endmodule

// File: tb/tb_johnson_counter_param.sv
// tb/tb_johnson_counter_param.sv - self-checking bench for johnson_counter_param (WIDTH=4 and WIDTH=7)
module tb_johnson_counter_param;
  import johnson_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;

  logic       en4 = 1'b0, dir4 = 1'b0, ld4 = 1'b0;
  logic [3:0] lv4 = '0;
  logic [3:0] q4;
  logic [2:0] ph4;
  logic       w4, e4;

  logic       en7 = 1'b0, dir7 = 1'b0, ld7 = 1'b0;
  logic [6:0] lv7 = '0;
  logic [6:0] q7;
  logic [3:0] ph7;
  logic       w7, e7;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: phase index, or -1 for an illegal (corrupted) state.
  int m4 = 0;
  int m7 = 3;
  logic x_w4, x_e4, x_w7, x_e7;

  johnson_counter_param #(.WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .en(en4), .dir(dir4), .load(ld4), .load_val(lv4),
    .q_out(q4), .phase(ph4), .wrap(w4), .err(e4)
  );

  johnson_counter_param #(.WIDTH(7), .RESET_VAL(7'b0000111)) dut7 (
    .clk(clk), .reset_n(reset_n), .en(en7), .dir(dir7), .load(ld7), .load_val(lv7),
    .q_out(q7), .phase(ph7), .wrap(w7), .err(e7)
  );

  always #5 clk = ~clk;

  // Code at phase p: p ones from the LSB for p<=w, else ones in the top 2w-p bits.
  function automatic int code_of(input int w, input int p);
    int mask;
    mask = (1 << w) - 1;
    if (p <= w) return (1 << p) - 1;
    return mask ^ ((1 << (p - w)) - 1);
  endfunction

  function automatic int phase_of(input int w, input int code);
    for (int p = 0; p < 2 * w; p++) begin
      if (code_of(w, p) == code) return p;
    end
    return -1;
  endfunction

  task automatic model_step(input int w, inout int ph, input logic en, input logic dir,
                            input logic ld, input int lv, output logic ew, output logic ee);
    int lp;
    ew = 1'b0;
    ee = 1'b0;
    if (ld) begin
      lp = phase_of(w, lv);
      if (lp < 0) begin
        ph = 0;
        ee = 1'b1;
      end else begin
        ph = lp;
      end
    end else if (ph < 0) begin
      ph = 0;
      ee = 1'b1;
    end else if (en) begin
      if (dir == DIR_DOWN) begin
        ew = (ph == 0);
        ph = (ph + 2 * w - 1) % (2 * w);
      end else begin
        ew = (ph == 2 * w - 1);
        ph = (ph + 1) % (2 * w);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("q4", 32'(q4), code_of(4, m4));
    chk("phase4", 32'(ph4), m4);
    chk("wrap4", 32'(w4), 32'(x_w4));
    chk("err4", 32'(e4), 32'(x_e4));
    chk("q7", 32'(q7), code_of(7, m7));
    chk("phase7", 32'(ph7), m7);
    chk("wrap7", 32'(w7), 32'(x_w7));
    chk("err7", 32'(e7), 32'(x_e7));
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    model_step(4, m4, en4, dir4, ld4, int'(lv4), x_w4, x_e4);
    model_step(7, m7, en7, dir7, ld7, int'(lv7), x_w7, x_e7);
    check_all();
  endtask

  initial begin
    int wc;
    x_w4 = 1'b0; x_e4 = 1'b0; x_w7 = 1'b0; x_e7 = 1'b0;

    // Reset state
    #6;
    check_all();
    #6;
    reset_n = 1'b1;

    // 1: count up 10 steps from 0000, exactly one wrap
    en4 = 1'b1; dir4 = DIR_UP;
    wc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (w4 === 1'b1) begin
        wc++;
        chk("t1_wrap_with_zero", 32'(q4), 32'h0);
      end
    end
    chk("t1_wrap_count", wc, 1);

    // 2: load 0000, count down 5, then reverse mid-run
    ld4 = 1'b1; lv4 = 4'b0000; en4 = 1'b0;
    tick();
    ld4 = 1'b0; en4 = 1'b1; dir4 = DIR_DOWN;
    tick();
    chk("t2_down_first", 32'(q4), 32'b1000);
    chk("t2_down_wrap", 32'(w4), 32'h1);
    for (int i = 0; i < 4; i++) tick();
    dir4 = DIR_UP;
    tick();
    chk("t2_reverse", 32'(q4), 32'b1111);
    tick();

    // 3: legal load with en high, then illegal load
    ld4 = 1'b1; lv4 = 4'b0111;
    tick();
    chk("t3_load_phase", 32'(ph4), 32'd3);
    lv4 = 4'b0101;
    tick();
    chk("t3_bad_load_err", 32'(e4), 32'h1);
    ld4 = 1'b0; en4 = 1'b0;
    tick();
    chk("t3_err_one_cycle", 32'(e4), 32'h0);

    // 4: corrupt state to 1010 with en low, expect recovery then normal counting
    force dut4.r_q = 4'b1010;
    #1;
    release dut4.r_q;
    #1;
    chk("t4_forced", 32'(q4), 32'b1010);
    m4 = -1;
    tick();
    chk("t4_recovered", 32'(q4), 32'h0);
    en4 = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // 5: hold at 1110 for 5 clocks, then asynchronous reset mid-cycle
    ld4 = 1'b1; lv4 = 4'b1110;
    tick();
    ld4 = 1'b0; en4 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t5_hold_phase", 32'(ph4), 32'd5);
    en4 = 1'b1;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    m4 = 0; m7 = 3;
    x_w4 = 1'b0; x_e4 = 1'b0; x_w7 = 1'b0; x_e7 = 1'b0;
    check_all();
    #2;
    reset_n = 1'b1;
    en4 = 1'b0;

    // 6: WIDTH=7 from 0000111, 14 up steps return home with one wrap
    en7 = 1'b1; dir7 = DIR_UP;
    wc = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (w7 === 1'b1) wc++;
    end
    chk("t6_wrap_count", wc, 1);
    chk("t6_home", 32'(q7), 32'b0000111);
    en7 = 1'b0;

    // Random mixed traffic on both instances
    for (int i = 0; i < 400; i++) begin
      en4  = ($urandom_range(0, 3) != 0);
      dir4 = 1'($urandom_range(0, 1));
      ld4  = ($urandom_range(0, 7) == 0);
      lv4  = ($urandom_range(0, 1) != 0) ? 4'(code_of(4, $urandom_range(0, 7)))
                                         : 4'($urandom_range(0, 15));
      en7  = ($urandom_range(0, 3) != 0);
      dir7 = 1'($urandom_range(0, 1));
      ld7  = ($urandom_range(0, 7) == 0);
      lv7  = ($urandom_range(0, 1) != 0) ? 7'(code_of(7, $urandom_range(0, 13)))
                                         : 7'($urandom_range(0, 127));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
